userio_wheel_keys: RTL and testbench
====================================

Name: userio_wheel_keys

Overview:
- Downstream consumer of the PS/2 mouse decoder's Z (scroll-wheel) counter.
- Converts each unit step of the Z counter into an Amiga NewMouse rawkey press/release pair:
  - wheel up: 0x7A
  - wheel down: 0x7B
- Events are delivered over a valid/ready handshake into the keyboard-injection path of userio.
- Runs on the 28 MHz clock, qualified by clk7_en, same as the mouse decoder.

Parameters:
- UP_CODE, 8'h7A, rawkey emitted for a positive Z step.
- DOWN_CODE, 8'h7B, rawkey emitted for a negative Z step.
- GAP_TICKS, 16'd1024, clk7_en ticks between press acceptance and release presentation.
- MAX_BACKLOG, 8'd8, maximum number of unconsumed Z steps retained (1..127).

Ports:
- clk  in  1  28 MHz system clock.
- reset  in  1  synchronous, active-high reset.
- clk7_en  in  1  7 MHz clock enable; all state advances only when high.
- enable  in  1  wheel-to-key conversion enabled.
- zcount  in  8  Z counter from mouse decoder, free-running, wraps mod 256.
- sof  in  1  start-of-frame pulse, one clk7_en cycle wide.
- key_code  out  8  rawkey code; bit7 = release.
- key_valid  out  1  key_code valid, held until accepted.
- key_ready  in  1  consumer accepts key_code when key_valid && key_ready && clk7_en.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (clk7_en need not be high):
  - zlast = 8'h00, state = IDLE.
  - key_valid = 0, key_code = 8'h00, busy = 0, dir = 0.
- Delta arithmetic: delta = zcount - zlast, 8-bit two's complement.
  - delta[7] = 0 and delta != 0: up.
  - delta[7] = 1: down. delta = 0x80 counts as down, magnitude 128.
  - mag = |delta|, 8-bit.
- IDLE:
  - busy = 0, key_valid = 0.
  - If !enable: zlast <= zcount every clk7_en cycle; stepping stops, backlog is discarded.
  - Else if delta != 0:
    - Latch dir.
    - Up: zlast <= (mag > MAX_BACKLOG) ? zcount - MAX_BACKLOG + 1 : zlast + 1.
    - Down: zlast <= (mag > MAX_BACKLOG) ? zcount + MAX_BACKLOG - 1 : zlast - 1.
    - Effect: remaining backlog after consuming one step = min(mag-1, MAX_BACKLOG-1).
    - Next state is PRESS.
- PRESS:
  - key_valid = 1, key_code = dir ? DOWN_CODE : UP_CODE.
  - On accept: clear gap counter, next state GAP.
- GAP:
  - key_valid = 0.
  - Counter increments per clk7_en.
  - At count == GAP_TICKS-1, next state RELEASE.
- RELEASE:
  - key_valid = 1, key_code = (dir ? DOWN_CODE : UP_CODE) | 8'h80.
  - On accept, next state WAIT (see optional feature).
- WAIT: next state IDLE; key_valid = 0.
- Timing and handshake rules:
  - Latency: delta appears → key_valid high on the second clk7_en cycle (IDLE registers, PRESS presents).
  - key_code and key_valid stay stable while key_valid && !key_ready.
  - key_code keeps its last value when key_valid = 0.
- enable dropping mid-sequence:
  - The current press/release pair completes, so no key is left stuck down.
  - No further steps are taken; zlast resyncs once back in IDLE.
- zcount changing during a sequence: no effect until IDLE; the backlog clamp is applied then.
- Direction reversal while busy: the net delta is evaluated at IDLE; opposite steps cancel arithmetically.
- Reset mid-sequence: immediate return to reset values; a press without its release may be lost downstream, and this is accepted.

Optional Feature:
- Macro: USERIO_WHEEL_SOF_PACE_EN.
- Defined:
  - WAIT holds until sof is seen high on a clk7_en cycle, then goes to IDLE.
  - At most one press/release pair starts per video frame.
  - A sof in the same cycle as RELEASE acceptance does not count.
- Undefined:
  - WAIT lasts exactly one clk7_en cycle.
  - sof is ignored entirely (may be left unconnected).

Test Plan:
- Reset, enable = 1, key_ready = 1, zcount 0 → 1 → expect key_code 0x7A press, then GAP_TICKS clk7_en ticks with key_valid = 0, then 0xFA; busy returns to 0; zlast = 1.
- zcount 0x05 → 0x03 with key_ready = 1 → exactly two 0x7B/0xFB pairs; no further events.
- zcount jumps 0 → 0x20, MAX_BACKLOG = 8 → exactly 8 up pairs total, then idle.
- key_ready held low 50 cycles during PRESS → key_valid = 1 and key_code = 0x7A stable throughout; advances one cycle after key_ready rises.
- enable = 0 asserted during GAP after a 3-step jump → current release 0xFA still delivered; no further pairs; zcount changes while disabled produce nothing.
- USERIO_WHEEL_SOF_PACE_EN defined, 3-step jump, sof every 2000 clk7 ticks → second press never starts before the first sof after release acceptance; undefined build: pairs are back-to-back with a 1-cycle WAIT.

Source files
------------

// File: rtl/userio_wheel_keys.sv
// Converts unit steps of the mouse Z counter into NewMouse wheel rawkey press/release pairs.
// Optional USERIO_WHEEL_SOF_PACE_EN limits the key pairs to one per video frame.
module userio_wheel_keys #(
  parameter logic [7:0]  UP_CODE     = 8'h7A,
  parameter logic [7:0]  DOWN_CODE   = 8'h7B,
  parameter logic [15:0] GAP_TICKS   = 16'd1024,
  parameter logic [7:0]  MAX_BACKLOG = 8'd8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk7_en,
  input  logic       enable,
  input  logic [7:0] zcount,
  input  logic       sof,
  output logic [7:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS,
    S_GAP,
    S_RELEASE,
    S_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  zlast_q, zlast_d;
  logic        dir_q, dir_d;
  logic [7:0]  code_q, code_d;
  logic [15:0] gap_q, gap_d;
  logic [7:0]  delta;
  logic [7:0]  mag;
  logic        clamp;

`ifndef USERIO_WHEEL_SOF_PACE_EN
  logic unused_sof;
  assign unused_sof = sof;
`endif

  assign key_valid = (state_q == S_PRESS) || (state_q == S_RELEASE);
  assign key_code  = code_q;
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      zlast_q <= 8'h00;
      dir_q   <= 1'b0;
      code_q  <= 8'h00;
      gap_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      zlast_q <= zlast_d;
      dir_q   <= dir_d;
      code_q  <= code_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    zlast_d = zlast_q;
    dir_d   = dir_q;
    code_d  = code_q;
    gap_d   = gap_q;
    delta   = zcount - zlast_q;
    mag     = delta[7] ? (8'd0 - delta) : delta;
    clamp   = (mag > MAX_BACKLOG);
    if (clk7_en) begin
      unique case (state_q)
        S_IDLE: begin
          if (!enable) begin
            zlast_d = zcount;
          end else if (delta != 8'd0) begin
            dir_d   = delta[7];
            code_d  = delta[7] ? DOWN_CODE : UP_CODE;
            state_d = S_PRESS;
            // Clamp leaves at most MAX_BACKLOG-1 steps pending after this one
            if (delta[7]) begin
              zlast_d = clamp ? (zcount + MAX_BACKLOG - 8'd1)
                              : (zlast_q - 8'd1);
            end else begin
              zlast_d = clamp ? (zcount - MAX_BACKLOG + 8'd1)
                              : (zlast_q + 8'd1);
            end
          end
        end
        S_PRESS: begin
          if (key_ready) begin
            gap_d   = 16'd0;
            state_d = S_GAP;
          end
        end
        S_GAP: begin
          gap_d = gap_q + 16'd1;
          if (gap_q == GAP_TICKS - 16'd1) begin
            code_d  = (dir_q ? DOWN_CODE : UP_CODE) | 8'h80;
            state_d = S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (key_ready) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
`ifdef USERIO_WHEEL_SOF_PACE_EN
          if (sof) begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_userio_wheel_keys.sv
// Scoreboard bench for userio_wheel_keys: expected rawkeys queued at stimulus,
// popped on each accepted handshake; gap and inter-pair spacing measured on the fly.
module tb_userio_wheel_keys;

  localparam logic [15:0] GAP  = 16'd20;
  localparam logic [7:0]  MAXB = 8'd8;
  localparam int          SOFP = 100;

  logic       clk;
  logic       reset;
  logic       clk7_en;
  logic       enable;
  logic [7:0] zcount;
  logic       sof;
  logic [7:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       busy;

  int checks;
  int failures;
  int acc_cnt;
  int tick;
  logic [7:0] exp_q[$];
  int wait_q[$];
  int sofs_q[$];

  userio_wheel_keys #(
    .UP_CODE    (8'h7A),
    .DOWN_CODE  (8'h7B),
    .GAP_TICKS  (GAP),
    .MAX_BACKLOG(MAXB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clk7_en  (clk7_en),
    .enable   (enable),
    .zcount   (zcount),
    .sof      (sof),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // clk7_en every other clk; sof one tick wide every SOFP ticks
  initial begin
    clk7_en = 1'b0;
    sof = 1'b0;
    tick = 0;
    forever begin
      @(posedge clk);
      #1;
      clk7_en = ~clk7_en;
      if (clk7_en) begin
        tick++;
        sof = ((tick % SOFP) == 0);
      end else begin
        sof = 1'b0;
      end
    end
  end

  // Handshake monitor / scoreboard
  initial begin
    logic [7:0] e;
    bit in_gap, in_wait, sof_seen;
    int gap_cnt, wait_cnt;
    in_gap = 0;
    in_wait = 0;
    sof_seen = 0;
    gap_cnt = 0;
    wait_cnt = 0;
    acc_cnt = 0;
    forever begin
      @(negedge clk);
      if (in_wait && key_valid === 1'b1) begin
        wait_q.push_back(wait_cnt);
        sofs_q.push_back(int'(sof_seen));
        in_wait = 0;
      end
      if (in_wait && clk7_en && sof) sof_seen = 1;
      if (in_wait && clk7_en) wait_cnt++;
      if (in_gap && clk7_en && key_valid === 1'b0) gap_cnt++;
      if (key_valid === 1'b1 && key_ready && clk7_en) begin
        acc_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_key got=%h required=none", key_code);
        end else begin
          e = exp_q.pop_front();
          if (key_code !== e) begin
            failures++;
            $display("FAIL key_code got=%h required=%h", key_code, e);
          end
        end
        if (key_code[7]) begin
          checks++;
          if (gap_cnt !== int'(GAP)) begin
            failures++;
            $display("FAIL gap_ticks got=%0d required=%0d", gap_cnt, GAP);
          end
          in_gap = 0;
          in_wait = 1;
          wait_cnt = 0;
          sof_seen = 0;
        end else begin
          in_gap = 1;
          gap_cnt = 0;
        end
      end
    end
  end

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pairs(input logic [7:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(c);
      exp_q.push_back(c | 8'h80);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    repeat (4) @(negedge clk);
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20000) begin
      failures++;
      $display("FAIL %s_timeout busy=%b pending=%0d required idle",
               nm, busy, exp_q.size());
    end
    repeat (4 * int'(GAP)) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_settle busy=%b pending=%0d required 0/0",
               nm, busy, exp_q.size());
    end
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (key_valid !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL %s_no_valid got=%b required=1", nm, key_valid);
    end
  endtask

  task automatic resync(input logic [7:0] z);
    drv();
    enable = 1'b0;
    zcount = z;
    repeat (6) drv();
    enable = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) drv();
    @(negedge clk);
    checks += 3;
    if (key_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b required=0", key_valid);
    end
    if (key_code !== 8'h00) begin
      failures++;
      $display("FAIL reset_code got=%h required=00", key_code);
    end
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b required=0", busy);
    end
    drv();
    reset = 1'b0;
    enable = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_zlast_idle busy=%b required=0", busy);
    end
  endtask

  task automatic test_single_up();
    int n, a0;
    a0 = acc_cnt;
    push_pairs(8'h7A, 1);
    drv();
    zcount = 8'h01;
    n = 0;
    forever begin
      @(negedge clk);
      if (key_valid === 1'b1 || n > 20) break;
      if (clk7_en) n++;
    end
    checks += 2;
    if (n !== 1) begin
      failures++;
      $display("FAIL latency ticks=%0d required=1", n);
    end
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_press got=%b required=1", busy);
    end
    wait_idle("single_up");
    checks++;
    if (acc_cnt - a0 !== 2) begin
      failures++;
      $display("FAIL single_up_count got=%0d required=2", acc_cnt - a0);
    end
  endtask

  task automatic test_down_two();
    int a0;
    resync(8'h05);
    a0 = acc_cnt;
    push_pairs(8'h7B, 2);
    zcount = 8'h03;
    wait_idle("down_two");
    checks++;
    if (acc_cnt - a0 !== 4) begin
      failures++;
      $display("FAIL down_two_count got=%0d required=4", acc_cnt - a0);
    end
  endtask

  task automatic test_backlog_clamp();
    int a0;
    resync(8'h00);
    a0 = acc_cnt;
    push_pairs(8'h7A, int'(MAXB));
    zcount = 8'h20;
    wait_idle("backlog");
    checks++;
    if (acc_cnt - a0 !== 2 * int'(MAXB)) begin
      failures++;
      $display("FAIL backlog_count got=%0d required=%0d",
               acc_cnt - a0, 2 * int'(MAXB));
    end
  endtask

  task automatic test_ready_stall();
    int bad, n;
    push_pairs(8'h7A, 1);
    drv();
    key_ready = 1'b0;
    zcount = 8'h21;
    wait_valid("stall");
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (key_valid !== 1'b1 || key_code !== 8'h7A) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stall_hold bad_cycles=%0d required=0", bad);
    end
    drv();
    key_ready = 1'b1;
    n = 0;
    while (key_valid === 1'b1 && n < 4) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (key_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_release got_valid=%b required=0", key_valid);
    end
    wait_idle("stall");
  endtask

  task automatic test_enable_drop();
    int a0, n;
    a0 = acc_cnt;
    push_pairs(8'h7A, 1);
    drv();
    zcount = 8'h24;
    n = 0;
    while (acc_cnt == a0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    drv();
    enable = 1'b0;
    repeat (10) drv();
    zcount = 8'h30;
    repeat (3 * int'(GAP)) drv();
    zcount = 8'h10;
    wait_idle("enable_drop");
    checks++;
    if (acc_cnt - a0 !== 2) begin
      failures++;
      $display("FAIL enable_drop_count got=%0d required=2", acc_cnt - a0);
    end
  endtask

  task automatic test_back_to_back();
    int a0, w1, w2, s1, s2;
    resync(8'h40);
    a0 = acc_cnt;
    push_pairs(8'h7A, 3);
    zcount = 8'h43;
    wait_idle("pace");
    checks++;
    if (acc_cnt - a0 !== 6 || wait_q.size() < 2) begin
      failures++;
      $display("FAIL pace_count got=%0d waits=%0d required=6/2",
               acc_cnt - a0, wait_q.size());
    end else begin
      w1 = wait_q[wait_q.size() - 2];
      w2 = wait_q[wait_q.size() - 1];
      s1 = sofs_q[sofs_q.size() - 2];
      s2 = sofs_q[sofs_q.size() - 1];
`ifdef USERIO_WHEEL_SOF_PACE_EN
      checks += 2;
      if (s1 !== 1 || s2 !== 1) begin
        failures++;
        $display("FAIL pace_sof got=%0d/%0d required=1/1", s1, s2);
      end
      if (w1 < 2 || w2 < 2) begin
        failures++;
        $display("FAIL pace_wait got=%0d/%0d required>=2", w1, w2);
      end
`else
      checks++;
      if (w1 !== 2 || w2 !== 2) begin
        failures++;
        $display("FAIL b2b_wait got=%0d/%0d required=2/2 (s=%0d/%0d)",
                 w1, w2, s1, s2);
      end
`endif
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    enable = 1'b0;
    zcount = 8'h00;
    key_ready = 1'b1;
    test_reset();
    test_single_up();
    test_down_two();
    test_backlog_clamp();
    test_ready_stall();
    test_enable_drop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
